// File: rtl/spin_phase_sampler.sv
// Measures each oscillator lane's phase against ref_osc over WINDOW cycles; result valid WINDOW+2 cycles after start.
// Results stay held in DONE until spins_ready; start is only accepted in IDLE.
module spin_phase_sampler #(
   parameter int NUM_SPINS = 4,
   parameter int WINDOW    = 256,
   parameter int CNT_W     = $clog2(WINDOW+1)
) (
   input  logic                        clk,
   input  logic                        rstn,
   input  logic [NUM_SPINS-1:0]        osc,
   input  logic                        ref_osc,
   input  logic                        start,
   output logic                        busy,
   output logic                        spins_valid,
   input  logic                        spins_ready,
   output logic [NUM_SPINS-1:0]        spins,
   output logic [NUM_SPINS*CNT_W-1:0]  counts
);

   typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;

   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
   localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(WINDOW-1);
   localparam logic [CNT_W:0]   WIN_FULL = (CNT_W+1)'(WINDOW);

   state_t                          state_q, state_d;
   logic [NUM_SPINS-1:0]            osc_meta_q, osc_meta_d;
   logic [NUM_SPINS-1:0]            osc_sync_q, osc_sync_d;
   logic                            ref_meta_q, ref_meta_d;
   logic                            ref_sync_q, ref_sync_d;
   logic [CNT_W-1:0]                win_q, win_d;
   logic [NUM_SPINS-1:0][CNT_W-1:0] cnt_q, cnt_d;
   logic [NUM_SPINS-1:0]            spins_q, spins_d;
   logic [NUM_SPINS-1:0]            mism;

   always_comb begin
      osc_meta_d = osc;
      osc_sync_d = osc_meta_q;
      ref_meta_d = ref_osc;
      ref_sync_d = ref_meta_q;
      mism       = osc_sync_q ^ {NUM_SPINS{ref_sync_q}};
      state_d    = state_q;
      win_d      = win_q;
      cnt_d      = cnt_q;
      spins_d    = spins_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               cnt_d   = '0;
               win_d   = '0;
               spins_d = '0;
               state_d = SETTLE;
            end
         end
         // Two idle cycles so the sync chains hold post-start input levels.
         SETTLE: begin
            if (win_q == ONE) begin
               win_d   = '0;
               state_d = MEASURE;
            end else begin
               win_d = win_q + ONE;
            end
         end
         MEASURE: begin
            for (int i = 0; i < NUM_SPINS; i++) begin
               cnt_d[i] = cnt_q[i] + {{(CNT_W-1){1'b0}}, mism[i]};
            end
            if (win_q == WIN_LAST) begin
               // Strict majority of mismatches means anti-phase; a tie reads as in-phase.
               for (int i = 0; i < NUM_SPINS; i++) begin
                  spins_d[i] = ({cnt_d[i], 1'b0} > WIN_FULL);
               end
               state_d = DONE;
            end else begin
               win_d = win_q + ONE;
            end
         end
         DONE: begin
            if (spins_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= IDLE;
         osc_meta_q <= '0;
         osc_sync_q <= '0;
         ref_meta_q <= 1'b0;
         ref_sync_q <= 1'b0;
         win_q      <= '0;
         cnt_q      <= '0;
         spins_q    <= '0;
      end else begin
         state_q    <= state_d;
         osc_meta_q <= osc_meta_d;
         osc_sync_q <= osc_sync_d;
         ref_meta_q <= ref_meta_d;
         ref_sync_q <= ref_sync_d;
         win_q      <= win_d;
         cnt_q      <= cnt_d;
         spins_q    <= spins_d;
      end
   end

   assign busy        = (state_q != IDLE);
   assign spins_valid = (state_q == DONE);
   assign spins       = spins_q;
   assign counts      = cnt_q;

endmodule

// File: doc/spin_phase_sampler.md
# spin_phase_sampler

Downstream readout stage for the oscillator array: samples the asynchronous ring-oscillator outputs of `NUM_SPINS` spin cells (the `sout`/`dout` nets of shorted or coupled cells) against a reference oscillator. It measures phase over a fixed window of `WINDOW` clock cycles and produces one binary spin value per lane. Each lane reports in-phase (0) or anti-phase (1) with the reference. Results are handed to the host-side logic through a valid/ready handshake.

## Interface
Parameters:
- `NUM_SPINS`, 4, number of oscillator lanes sampled in parallel.
- `WINDOW`, 256, number of clock cycles accumulated per measurement; must be even and ≥ 2.
- `CNT_W`, `$clog2(WINDOW+1)`, derived width of each mismatch counter; not to be overridden.

Ports:
- `clk`  input  1  sampling clock.
- `rstn`  input  1  reset; asynchronous, active-low.
- `osc`  input  `NUM_SPINS`  raw oscillator outputs, asynchronous to `clk`.
- `ref_osc`  input  1  reference-phase oscillator, asynchronous to `clk`.
- `start`  input  1  request a measurement; accepted only in IDLE.
- `busy`  output  1  high whenever state ≠ IDLE.
- `spins_valid`  output  1  result available (state DONE).
- `spins_ready`  input  1  consumer accepts the result.
- `spins`  output  `NUM_SPINS`  bit i = 1 if lane i is anti-phase with `ref_osc`.
- `counts`  output  `NUM_SPINS*CNT_W`  lane i mismatch count at bits `[i*CNT_W +: CNT_W]`.

## Operation
- Synchronizers: each `osc[i]` and `ref_osc` passes through its own 2-flop synchronizer. The synchronizers run continuously in all states and reset to 0.
- Mismatch per lane: `m[i] = osc_sync[i] ^ ref_sync`.
- State machine, with states IDLE, SETTLE, MEASURE and DONE:
  - IDLE: when `start`=1, clear all counters and the settle/window counter, then go to SETTLE.
  - SETTLE: lasts exactly 2 cycles with no accumulation; this flushes the synchronizers. Then go to MEASURE.
  - MEASURE: on each of `WINDOW` consecutive edges, `cnt[i] += m[i]`. After the `WINDOW`-th edge, go to DONE.
    - On that same edge, register `spins[i] = (2*cnt_final[i] > WINDOW)`, where `cnt_final` includes the last sample.
    - A count of exactly `WINDOW/2` gives `spins[i]=0`.
  - DONE: `spins_valid`=1. When `spins_ready`=1, go to IDLE.
- `start` is ignored outside IDLE. It is not queued.
- Counters never exceed `WINDOW`, so there is no overflow. The window counter runs from 0 to WINDOW-1 and is `CNT_W` bits wide.
- `spins` and `counts` hold their last result until the next accepted `start` clears them. They are stable throughout DONE.
- Reset state: all outputs 0, state IDLE, all counters 0.

## Timing
- `start` sampled high at edge E0 (state IDLE) gives state SETTLE after E0.
- SETTLE occupies edges E1 and E2.
- Accumulation happens at edges E3 through E(2+WINDOW).
- `spins_valid`=1 after E(2+WINDOW). Start-to-valid latency is therefore WINDOW+2 cycles.
- Handshake completes on the edge where `spins_valid`=1 and `spins_ready`=1. Both `spins_valid` and `busy` are 0 after that edge.
- A `start` on the handshake edge is ignored because the state is still DONE. The earliest accepted restart is the next cycle.
- `spins_ready` is a don't-care outside DONE.
- `rstn` low at any time, including mid-MEASURE or in DONE: all outputs, state and counters go to 0 immediately. Operation resumes from IDLE on the first edge after deassertion.
- Input phase relative to the sample point is not tracked. Only synchronized levels count, so results are statistical for oscillators asynchronous to `clk`.

## Test plan
Directed tests use NUM_SPINS=4 and WINDOW=8 unless noted.

- **In-phase:** `osc` = {4{`ref_osc`}}, with `ref_osc` toggling every 3 cycles. Pulse `start` → `spins_valid` rises 10 cycles after the start edge; `spins`=4'b0000 and every count = 0.
- **Anti-phase:** `osc` = {4{~`ref_osc`}}. Pulse `start` → `spins`=4'b1111 and every count = 8.
- **Tie and per-lane:** `ref_osc` = 0 constant; `osc` = {1, 0, `clk`-synchronous square of period 2, 0}, with lane 3 first. Expected counts are 8, 0, 4, 0 and `spins`=4'b1000; the tie at 4 resolves to 0.
- **Backpressure:** hold `spins_ready`=0 for 12 cycles in DONE and pulse `start` meanwhile. `spins_valid`, `spins` and `counts` stay stable and `busy` stays 1. Raising `spins_ready` returns the block to IDLE one edge later with `busy`=0.
- **Reset mid-measure:** assert `rstn`=0 asynchronously 4 cycles into MEASURE → `busy`, `spins_valid`, `spins` and `counts` are 0 immediately. After release, a fresh `start` gives correct anti-phase results.
- **Ignored start:** pulse `start` repeatedly during SETTLE and MEASURE. Exactly one result is produced and latency is unchanged at WINDOW+2.
